// File: rtl/hilo_muldiv_seq.sv
// HI/LO sequencer: iterative shift-add multiply (with accumulate) and restoring divide,
// plus single-cycle MTHI/MTLO, behind a start/busy/done handshake.
module hilo_muldiv_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_req,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] hi_n, lo_n;
   logic             busy_n, done_n, dz_n;
   logic [2:0]       op_q, op_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [PW-1:0]    mcand, mcand_n, acc, acc_n, prod;
   logic [WIDTH-1:0] mplier, mplier_n, dvsr, dvsr_n, quo, quo_n, rem, rem_n;
   logic             neg_p, neg_p_n, neg_r, neg_r_n;
   logic [WIDTH:0]   shifted, diff;
   logic             sgn, is_mt;
   logic [WIDTH-1:0] a_abs, b_abs;

   // Signed ops work on magnitudes; the sign is restored in FIX.
   assign sgn   = ~op[0];
   assign is_mt = op[2] & op[1];
   assign a_abs = (sgn & a[WIDTH-1]) ? -a : a;
   assign b_abs = (sgn & b[WIDTH-1]) ? -b : b;

   assign stall = rd_req & (busy | (start & ~busy & ~is_mt));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      hi_n     = hi;
      lo_n     = lo;
      busy_n   = busy;
      done_n   = 1'b0;
      dz_n     = 1'b0;
      op_n     = op_q;
      cnt_n    = cnt;
      mcand_n  = mcand;
      mplier_n = mplier;
      acc_n    = acc;
      dvsr_n   = dvsr;
      quo_n    = quo;
      rem_n    = rem;
      neg_p_n  = neg_p;
      neg_r_n  = neg_r;
      shifted  = {rem, quo[WIDTH-1]};
      diff     = shifted - {1'b0, dvsr};
      prod     = neg_p ? -acc : acc;

      case (state)
         IDLE: begin
            if (start) begin
               op_n = op;
               if (is_mt) begin
                  if (op[0]) lo_n = a;
                  else       hi_n = a;
                  done_n = 1'b1;
               end else begin
                  mcand_n  = PW'(a_abs);
                  mplier_n = b_abs;
                  acc_n    = '0;
                  dvsr_n   = b_abs;
                  quo_n    = a_abs;
                  rem_n    = '0;
                  cnt_n    = '0;
                  neg_p_n  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r_n  = sgn & a[WIDTH-1];
                  busy_n   = 1'b1;
                  state_n  = op[2] ? DIV : MUL;
               end
            end
         end
         MUL: begin
            if (mplier[0]) acc_n = acc + mcand;
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt + CW'(1);
            if (cnt == LAST) state_n = FIX;
         end
         DIV: begin
            // Restoring step: keep the trial subtraction only if it did not borrow.
            rem_n = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], ~diff[WIDTH]};
            cnt_n = cnt + CW'(1);
            if (cnt == LAST) state_n = FIX;
         end
         FIX: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            if (op_q[2]) begin
               if (dvsr == '0) begin
                  dz_n = 1'b1;
               end else begin
                  lo_n = neg_p ? -quo : quo;
                  hi_n = neg_r ? -rem : rem;
               end
            end else if (op_q[1]) begin
               {hi_n, lo_n} = {hi, lo} + prod;
            end else begin
               {hi_n, lo_n} = prod;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         op_q     <= '0;
         cnt      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         dvsr     <= '0;
         quo      <= '0;
         rem      <= '0;
         neg_p    <= 1'b0;
         neg_r    <= 1'b0;
      end else begin
         hi       <= hi_n;
         lo       <= lo_n;
         busy     <= busy_n;
         done     <= done_n;
         div_zero <= dz_n;
         op_q     <= op_n;
         cnt      <= cnt_n;
         mcand    <= mcand_n;
         mplier   <= mplier_n;
         acc      <= acc_n;
         dvsr     <= dvsr_n;
         quo      <= quo_n;
         rem      <= rem_n;
         neg_p    <= neg_p_n;
         neg_r    <= neg_r_n;
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Scoreboard bench for hilo_muldiv_seq: arithmetic reference model, queued expectations,
// negedge monitor checking results, latency, busy, stall and HI/LO hold.
module tb_hilo_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        rd_req;
   logic        busy, done, div_zero, stall;
   logic [31:0] hi, lo;

   hilo_muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd_req(rd_req),
      .busy(busy), .done(done), .div_zero(div_zero), .stall(stall), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          busy_until = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [31:0] comm_hi = '0, comm_lo = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
   function automatic exp_t ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [63:0] hl;
      longint      sx, sy, q, r;
      hl = {m_hi, m_lo};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e.dz = 1'b0;
      case (o)
         3'd0: hl = sx * sy;
         3'd1: hl = {32'b0, x} * {32'b0, y};
         3'd2: hl = hl + 64'(sx * sy);
         3'd3: hl = hl + {32'b0, x} * {32'b0, y};
         3'd4, 3'd5: begin
            if (y == 0) begin
               e.dz = 1'b1;
            end else begin
               if (o == 3'd4) begin q = sx / sy; r = sx % sy; end
               else begin q = longint'(x / y); r = longint'(x % y); end
               hl = {r[31:0], q[31:0]};
            end
         end
         3'd6: hl[63:32] = x;
         default: hl[31:0] = x;
      endcase
      e.hi = hl[63:32];
      e.lo = hl[31:0];
      e.cyc = 0;
      return e;
   endfunction

   // Called and returns aligned at posedge+1.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
      exp_t e;
      int   n;
      int   guard;
      guard = 0;
      while (cyc < busy_until) begin
         @(posedge clk); #1;
         guard++;
         if (guard > 100) begin
            total++; bad++;
            $display("FAIL issue_wait act=busy exp=idle (cyc %0d)", cyc);
            return;
         end
      end
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      n = cyc;
      start = 1'b0; a = $urandom; b = $urandom;
      if (o < 3'd6) busy_until = n + 33;
      if (o >= 3'd6) chk("mt_busy", 64'(busy), 64'(0));
      if (push) begin
         e = ref_op(o, x, y);
         e.cyc = (o < 3'd6) ? n + 33 : n;
         m_hi = e.hi;
         m_lo = e.lo;
         sb.push_back(e);
      end
   endtask

   // Monitor: output checks decoupled from stimulus.
   always @(negedge clk) begin
      exp_t e;
      logic eb;
      if (!rst) begin
         eb = (cyc < busy_until);
         chk("busy", 64'(busy), 64'(eb));
         chk("stall", 64'(stall), 64'(rd_req & (eb | (start & ~eb & (op < 3'd6)))));
         if (done) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_done act=1 exp=0 (cyc %0d)", cyc);
            end else begin
               e = sb.pop_front();
               chk("done_cyc", 64'(cyc), 64'(e.cyc));
               chk("hi", 64'(hi), 64'(e.hi));
               chk("lo", 64'(lo), 64'(e.lo));
               chk("div_zero", 64'(div_zero), 64'(e.dz));
               comm_hi = e.hi;
               comm_lo = e.lo;
            end
         end else begin
            chk("div_zero_idle", 64'(div_zero), 64'(0));
            chk("hi_hold", 64'(hi), 64'(comm_hi));
            chk("lo_hold", 64'(lo), 64'(comm_lo));
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
               e = sb.pop_front();
               total++; bad++;
               $display("FAIL missing_done act=0 exp=1 (due cyc %0d)", e.cyc);
               comm_hi = e.hi;
               comm_lo = e.lo;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      int          guard;
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; rd_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a multiply discards it.
      issue(3'd6, 32'd5, 32'd0, 1'b1);
      issue(3'd0, 32'd7, 32'd6, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      busy_until = 0; m_hi = '0; m_lo = '0; comm_hi = '0; comm_lo = '0;
      #1;
      chk("midrst_hi", 64'(hi), 64'(0));
      chk("midrst_lo", 64'(lo), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_done", 64'(done), 64'(0));
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      issue(3'd1, 32'd3, 32'd4, 1'b1);
      issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1);
      issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
      issue(3'd6, 32'd0, 32'd0, 1'b1);
      issue(3'd7, 32'hFFFFFFFF, 32'd0, 1'b1);
      issue(3'd3, 32'd1, 32'd1, 1'b1);
      issue(3'd2, 32'hFFFFFFFF, 32'd1, 1'b1);
      issue(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1);
      issue(3'd5, 32'd7, 32'd2, 1'b1);
      issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      issue(3'd7, 32'h1234, 32'd0, 1'b1);
      issue(3'd4, 32'd5, 32'd0, 1'b1);
      issue(3'd5, 32'd9, 32'd4, 1'b1);

      // Read stall across a multiply, with a start issued while busy.
      rd_req = 1'b1;
      issue(3'd0, 32'd7, 32'd6, 1'b1);
      repeat (3) @(posedge clk);
      #1 start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
      while (cyc <= busy_until) begin @(posedge clk); #1; end
      rd_req = 1'b0;

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
         if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
         rd_req = 1'($urandom_range(0, 1));
         issue(ro, ra, rb, 1'b1);
      end

      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (sb.size() > 0) begin
         total++; bad++;
         $display("FAIL drain act=%0d exp=0 pending", sb.size());
      end
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
